// File: rtl/fetch_stage_pkg.sv
// Shared types for the instruction fetch stage: machine words, trap records,
// decode-buffer entries, the fetch state machine encoding and trap causes.
package fetch_stage_pkg;

    typedef logic [31:0] word_t;
    typedef logic [31:0] insn_t;
    typedef logic [3:0]  cause_t;

    // Program counter value after reset and the fetch stride.
    localparam word_t InitialProgramCounter = 32'h0000_1000;
    localparam word_t InsnSize              = 32'd4;

    // Exception causes raised by fetch.
    localparam cause_t CauseInsnAddrMisaligned = 4'd0;
    localparam cause_t CauseInsnAccessFault    = 4'd1;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } FetchState;

    typedef struct packed {
        logic   valid;
        cause_t cause;
        word_t  value;
    } TrapInfo;

    typedef struct packed {
        word_t   pc;
        insn_t   insn;
        TrapInfo trap;
    } FetchEntry;

    // Build a valid trap record.
    function automatic TrapInfo make_trap(input cause_t cause, input word_t value);
        TrapInfo t;
        t.valid = 1'b1;
        t.cause = cause;
        t.value = value;
        return t;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Bundle of the fetch stage's memory, redirect and decode handshakes.
// The master view belongs to the fetch stage, the slave view to its
// surroundings (instruction memory, trap/branch logic and decode).
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    // Instruction memory request / response.
    logic    memReqValid;
    word_t   memReqAddr;
    logic    memReqReady;
    logic    memRespValid;
    insn_t   memRespInsn;
    logic    memRespError;

    // Flush and restart from the trap/branch logic.
    logic    redirectValid;
    word_t   redirectPc;

    // Decode-side entry stream.
    logic    outValid;
    logic    outReady;
    word_t   outPc;
    insn_t   outInsn;
    TrapInfo outTrap;

    modport master (
        output memReqValid, memReqAddr,
        input  memReqReady, memRespValid, memRespInsn, memRespError,
        input  redirectValid, redirectPc,
        output outValid, outPc, outInsn, outTrap,
        input  outReady
    );

    modport slave (
        input  memReqValid, memReqAddr,
        output memReqReady, memRespValid, memRespInsn, memRespError,
        output redirectValid, redirectPc,
        input  outValid, outPc, outInsn, outTrap,
        output outReady
    );

endinterface

// File: rtl/fetch_fifo.sv
// Decode buffer of the fetch stage: synchronous FIFO of FetchEntry with a
// flush input. A push into a full FIFO is accepted when a pop happens in
// the same cycle; clear overrides both push and pop.
module fetch_fifo
    import fetch_stage_pkg::*;
#(
    parameter int Depth = 4
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  i_clear,
    input  logic                  i_push,
    input  FetchEntry             i_push_data,
    input  logic                  i_pop,
    output FetchEntry             o_head,
    output logic [$clog2(Depth):0] o_count,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam int PtrW = $clog2(Depth);

    FetchEntry              r_mem [Depth];
    logic [PtrW-1:0]        r_wr_ptr;
    logic [PtrW-1:0]        r_rd_ptr;
    logic [PtrW:0]          r_count;
    logic                   w_do_push;
    logic                   w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (PtrW + 1)'(Depth));
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Entry storage: written on push, never reset.
    // NOTE: storage carries no reset; the count and pointers alone decide which entries are valid, so clearing the array would only cost logic.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_clear) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointer and occupancy bookkeeping; a clear empties the buffer.
    // NOTE: state is updated with non-blocking assignments so every register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + (PtrW + 1)'(w_do_push) - (PtrW + 1)'(w_do_pop);
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues in-order word fetches under a
// credit limit, buffers returned instructions (or fetch traps) for decode and
// restarts at a new PC on redirect.
// Optional build macro FETCH_STAGE_PERF_EN adds the perfFetchCount and
// perfDropCount event counters.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int FifoDepth = 4
) (
    input  logic          clk,
    input  logic          rstN,
    fetch_stage_if.master bus
`ifdef FETCH_STAGE_PERF_EN
    ,
    output logic [31:0]   perfFetchCount,
    output logic [31:0]   perfDropCount
`endif
);

    localparam int CntW = $clog2(FifoDepth) + 1;
    typedef logic [CntW-1:0] cnt_t;

    localparam logic [CntW:0] DepthLimit = (CntW + 1)'(FifoDepth);

    FetchState   r_state;
    FetchState   w_next_state;
    word_t       r_pc;
    word_t       r_resp_pc;
    cnt_t        r_inflight;
    cnt_t        r_drop_count;

    cnt_t        w_fifo_count;
    logic        w_fifo_full;
    logic        w_fifo_empty;
    FetchEntry   w_fifo_head;
    FetchEntry   w_push_entry;

    logic [CntW:0] w_occupancy;
    logic        w_credit;
    logic        w_pc_aligned;
    logic        w_req_valid;
    logic        w_req_fire;
    logic        w_resp_take;
    logic        w_resp_fault;
    logic        w_misalign_trap;
    logic        w_push;
    logic        w_pop;
    cnt_t        w_inflight_next;

    // Fetches in flight plus buffered entries may never exceed the buffer size,
    // so every response is guaranteed a slot.
    assign w_occupancy  = {1'b0, r_inflight} + {1'b0, w_fifo_count};
    assign w_credit     = (w_occupancy < DepthLimit);
    assign w_pc_aligned = (r_pc[1:0] == 2'b00);
    assign w_req_fire   = w_req_valid && bus.memReqReady;

    // Responses are kept only when nothing is pending to be dropped and no
    // redirect overrides them this cycle.
    assign w_resp_take  = bus.memRespValid && (r_drop_count == '0) && !bus.redirectValid;
    assign w_resp_fault = w_resp_take && bus.memRespError;

    assign w_push = w_resp_take || w_misalign_trap;
    assign w_pop  = !w_fifo_empty && bus.outReady && !bus.redirectValid;

    // Net in-flight count after this cycle's acceptance and response.
    assign w_inflight_next = r_inflight + cnt_t'(w_req_fire) - cnt_t'(bus.memRespValid);

    // FSM state register.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next state: a fetch trap halts, only a redirect resumes.
    always_comb begin
        w_next_state = r_state;
        if (bus.redirectValid) begin
            w_next_state = RUN;
        end else if (r_state == RUN && (w_resp_fault || w_misalign_trap)) begin
            w_next_state = HALT;
        end
    end

    // FSM outputs: request issue and the misaligned-PC trap.
    // NOTE: every signal written here gets a default first so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_req_valid     = 1'b0;
        w_misalign_trap = 1'b0;
        if (r_state == RUN && !bus.redirectValid) begin
            w_req_valid     = w_pc_aligned && w_credit;
            w_misalign_trap = !w_pc_aligned && (r_inflight == '0) && !w_fifo_full && !w_resp_take;
        end
    end

    // Entry pushed into the decode buffer: a returned word, an access fault
    // or a misaligned-PC trap.
    always_comb begin
        w_push_entry = '0;
        if (w_resp_take) begin
            w_push_entry.pc = r_resp_pc;
            if (bus.memRespError) begin
                w_push_entry.trap = make_trap(CauseInsnAccessFault, r_resp_pc);
            end else begin
                w_push_entry.insn = bus.memRespInsn;
            end
        end else begin
            w_push_entry.pc   = r_pc;
            w_push_entry.trap = make_trap(CauseInsnAddrMisaligned, r_pc);
        end
    end

    // PC, response PC and in-flight / drop bookkeeping.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_pc         <= InitialProgramCounter;
            r_resp_pc    <= InitialProgramCounter;
            r_inflight   <= '0;
            r_drop_count <= '0;
        end else begin
            r_inflight <= w_inflight_next;
            if (bus.redirectValid) begin
                r_pc         <= bus.redirectPc;
                r_resp_pc    <= bus.redirectPc;
                r_drop_count <= w_inflight_next;
            end else begin
                if (w_req_fire) begin
                    r_pc <= r_pc + InsnSize;
                end
                if (w_resp_take) begin
                    r_resp_pc <= r_resp_pc + InsnSize;
                end
                // After a fault every fetch still outstanding is stale.
                if (w_resp_fault) begin
                    r_drop_count <= w_inflight_next;
                end else if (bus.memRespValid && r_drop_count != '0) begin
                    r_drop_count <= r_drop_count - 1'b1;
                end
            end
        end
    end

    fetch_fifo #(
        .Depth       (FifoDepth)
    ) u_fifo (
        .clk         (clk),
        .rstN        (rstN),
        .i_clear     (bus.redirectValid),
        .i_push      (w_push),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop),
        .o_head      (w_fifo_head),
        .o_count     (w_fifo_count),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    assign bus.memReqValid = w_req_valid;
    assign bus.memReqAddr  = r_pc;
    assign bus.outValid    = !w_fifo_empty;
    assign bus.outPc       = w_fifo_head.pc;
    assign bus.outInsn     = w_fifo_head.insn;
    assign bus.outTrap     = w_fifo_head.trap;

`ifdef FETCH_STAGE_PERF_EN
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_drop;
    logic [31:0] w_drop_inc;

    // Discarded responses plus every entry a redirect flushes (a pop in the
    // redirect cycle is discarded, so the whole pre-edge count is flushed).
    assign w_drop_inc = 32'(bus.memRespValid && !w_resp_take)
                      + (bus.redirectValid ? 32'(w_fifo_count) : 32'd0);

    // Event counters; both wrap.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_perf_fetch <= '0;
            r_perf_drop  <= '0;
        end else begin
            if (w_resp_take && !bus.memRespError) begin
                r_perf_fetch <= r_perf_fetch + 32'd1;
            end
            r_perf_drop <= r_perf_drop + w_drop_inc;
        end
    end

    assign perfFetchCount = r_perf_fetch;
    assign perfDropCount  = r_perf_drop;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage. A behavioural memory answers fetches
// in order with random latency; a reference model (queues of outstanding
// fetch addresses and expected decode entries) predicts every output.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    localparam int Depth = 4;

    logic clk = 1'b0;
    logic rstN;
    always #5 clk = ~clk;

    fetch_stage_if bus ();

`ifdef FETCH_STAGE_PERF_EN
    logic [31:0] perf_fetch;
    logic [31:0] perf_drop;
`endif

    fetch_stage #(
        .FifoDepth      (Depth)
    ) dut (
        .clk            (clk),
        .rstN           (rstN),
        .bus            (bus)
`ifdef FETCH_STAGE_PERF_EN
        ,
        .perfFetchCount (perf_fetch),
        .perfDropCount  (perf_drop)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: outstanding fetches in issue order (dead ones belong
    // to a flushed or faulted stream) and the entries decode should see.
    typedef struct {
        word_t addr;
        bit    live;
    } ofetch_t;

    ofetch_t     m_out[$];
    FetchEntry   m_fifo[$];
    word_t       m_pc;
    bit          m_halted;
    logic [31:0] m_perf_fetch;
    logic [31:0] m_perf_drop;

    // Behavioural instruction memory.
    typedef struct {
        word_t addr;
        int    due;
    } mreq_t;

    mreq_t mem_q[$];
    int    cyc        = 0;
    int    acc_count  = 0;
    int    ready_pct  = 100;
    int    pop_pct    = 100;
    int    min_lat    = 0;
    int    max_lat    = 0;
    bit    err_en     = 1'b0;
    word_t err_addr   = '0;
    bit    rand_err   = 1'b0;

    function automatic insn_t mem_word(input word_t a);
        return (a ^ 32'hC0DE_0000) + 32'h0000_0011;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic FetchEntry trap_entry(input cause_t c, input word_t a);
        FetchEntry e;
        e.pc         = a;
        e.insn       = '0;
        e.trap.valid = 1'b1;
        e.trap.cause = c;
        e.trap.value = a;
        return e;
    endfunction

    function automatic void model_reset();
        m_out.delete();
        m_fifo.delete();
        m_pc         = 32'h0000_1000;
        m_halted     = 1'b0;
        m_perf_fetch = '0;
        m_perf_drop  = '0;
    endfunction

    function automatic bit model_req_valid(input bit redir);
        return !m_halted && (m_pc[1:0] == 2'b00)
               && ((m_out.size() + m_fifo.size()) < Depth) && !redir;
    endfunction

    // Advance the model across one clock edge.
    function automatic void model_step(input bit redir, input word_t rpc, input bit pop,
                                       input bit resp_v, input bit resp_err,
                                       input insn_t resp_insn, input bit req_fire);
        ofetch_t   head;
        FetchEntry e;
        bit        kill;
        bit        misalign;
        misalign = !m_halted && (m_pc[1:0] != 2'b00) && (m_out.size() == 0)
                   && (m_fifo.size() < Depth);
        kill = 1'b0;
        if (redir) begin
            m_perf_drop += 32'(m_fifo.size());
            m_fifo.delete();
            if (resp_v) begin
                void'(m_out.pop_front());
                m_perf_drop += 32'd1;
            end
            foreach (m_out[i]) m_out[i].live = 1'b0;
            m_pc     = rpc;
            m_halted = 1'b0;
            return;
        end
        if (pop) void'(m_fifo.pop_front());
        if (resp_v) begin
            head = m_out.pop_front();
            if (!head.live) begin
                m_perf_drop += 32'd1;
            end else if (resp_err) begin
                m_fifo.push_back(trap_entry(CauseInsnAccessFault, head.addr));
                kill = 1'b1;
            end else begin
                e.pc   = head.addr;
                e.insn = resp_insn;
                e.trap = '0;
                m_fifo.push_back(e);
                m_perf_fetch += 32'd1;
            end
        end
        if (req_fire) begin
            m_out.push_back('{addr: m_pc, live: 1'b1});
            m_pc = m_pc + 32'd4;
        end
        if (kill) begin
            foreach (m_out[i]) m_out[i].live = 1'b0;
            m_halted = 1'b1;
        end else if (misalign) begin
            m_fifo.push_back(trap_entry(CauseInsnAddrMisaligned, m_pc));
            m_halted = 1'b1;
        end
    endfunction

    task automatic compare_outputs(input bit exp_req);
        check("memReqValid", 64'(bus.memReqValid), 64'(exp_req));
        if (exp_req) check("memReqAddr", 64'(bus.memReqAddr), 64'(m_pc));
        check("outValid", 64'(bus.outValid), 64'(m_fifo.size() != 0));
        if (m_fifo.size() != 0) begin
            check("outPc", 64'(bus.outPc), 64'(m_fifo[0].pc));
            check("outInsn", 64'(bus.outInsn), 64'(m_fifo[0].insn));
            check("outTrap", 64'(bus.outTrap), 64'(m_fifo[0].trap));
        end
`ifdef FETCH_STAGE_PERF_EN
        check("perfFetchCount", 64'(perf_fetch), 64'(m_perf_fetch));
        check("perfDropCount", 64'(perf_drop), 64'(m_perf_drop));
`endif
    endtask

    // One clock cycle: called #1 after a rising edge, drives inputs, checks
    // outputs mid-cycle, then steps model and memory across the next edge.
    task automatic do_cycle(input bit redir, input word_t rpc);
        bit    exp_req;
        bit    pop;
        bit    acc;
        word_t acc_addr;
        bit    resp_v;
        bit    resp_err;
        insn_t resp_insn;
        bus.redirectValid = redir;
        bus.redirectPc    = rpc;
        bus.outReady      = ($urandom_range(0, 99) < pop_pct);
        bus.memReqReady   = ($urandom_range(0, 99) < ready_pct);
        resp_v = (mem_q.size() != 0) && (mem_q[0].due <= cyc);
        resp_err = 1'b0;
        if (resp_v) begin
            resp_insn = mem_word(mem_q[0].addr);
            if (err_en) resp_err = (mem_q[0].addr == err_addr);
            else        resp_err = rand_err && ($urandom_range(0, 39) == 0);
        end else begin
            resp_insn = $urandom;
        end
        bus.memRespValid = resp_v;
        bus.memRespInsn  = resp_insn;
        bus.memRespError = resp_err;
        #2;
        exp_req = model_req_valid(redir);
        compare_outputs(exp_req);
        pop      = (m_fifo.size() != 0) && bus.outReady;
        acc      = bus.memReqValid && bus.memReqReady;
        acc_addr = bus.memReqAddr;
        if (acc) acc_count++;
        model_step(redir, rpc, pop, resp_v, resp_err, resp_insn, exp_req && bus.memReqReady);
        @(posedge clk);
        #1;
        cyc++;
        if (resp_v) void'(mem_q.pop_front());
        if (acc) mem_q.push_back('{addr: acc_addr,
                                   due: cyc + min_lat + int'($urandom_range(0, max_lat - min_lat))});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) do_cycle(1'b0, '0);
    endtask

    task automatic idle_inputs();
        bus.memReqReady   = 1'b0;
        bus.memRespValid  = 1'b0;
        bus.memRespInsn   = '0;
        bus.memRespError  = 1'b0;
        bus.redirectValid = 1'b0;
        bus.redirectPc    = '0;
        bus.outReady      = 1'b0;
    endtask

    // Asynchronous reset in the middle of a cycle.
    task automatic mid_reset();
        idle_inputs();
        rstN = 1'b0;
        #1;
        check("rst_outValid", 64'(bus.outValid), 64'(0));
        check("rst_memReqValid", 64'(bus.memReqValid), 64'(1));
        check("rst_memReqAddr", 64'(bus.memReqAddr), 64'(32'h0000_1000));
`ifdef FETCH_STAGE_PERF_EN
        check("rst_perfFetch", 64'(perf_fetch), 64'(0));
        check("rst_perfDrop", 64'(perf_drop), 64'(0));
`endif
        model_reset();
        mem_q.delete();
        @(posedge clk);
        #1;
        rstN = 1'b1;
    endtask

    initial begin
        word_t ra;
        idle_inputs();
        model_reset();
        rstN = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("init_outValid", 64'(bus.outValid), 64'(0));
        check("init_memReqAddr", 64'(bus.memReqAddr), 64'(32'h0000_1000));
        rstN = 1'b1;

        // Streaming fetch with single-cycle memory.
        ready_pct = 100; pop_pct = 100; min_lat = 0; max_lat = 0;
        run(12);

        // Decode stalled: credit lets exactly Depth requests out.
        mid_reset();
        acc_count = 0;
        pop_pct = 0;
        run(12);
        check("credit_issue_count", 64'(acc_count), 64'(Depth));
        pop_pct = 100;
        run(10);

        // Redirect with several fetches in flight.
        min_lat = 3; max_lat = 3;
        run(6);
        do_cycle(1'b1, 32'h0000_2000);
        run(14);

        // Misaligned redirect traps and halts; an aligned redirect resumes.
        min_lat = 0; max_lat = 1;
        do_cycle(1'b1, 32'h0000_2002);
        run(8);
        do_cycle(1'b1, 32'h0000_3000);
        run(8);

        // Access fault on 0x1008 with later fetches still in flight.
        min_lat = 2; max_lat = 2;
        err_en = 1'b1; err_addr = 32'h0000_1008;
        do_cycle(1'b1, 32'h0000_1000);
        run(16);
        err_en = 1'b0;
        do_cycle(1'b1, 32'h0000_1100);
        run(8);

        // Redirect coinciding with a response and a decode pop.
        min_lat = 0; max_lat = 0;
        run(6);
        do_cycle(1'b1, 32'h0000_5000);
        run(8);

        // PC wraps past the top of the address space.
        do_cycle(1'b1, 32'hFFFF_FFF8);
        run(8);

        // Random traffic with faults, stalls and redirects.
        ready_pct = 70; pop_pct = 60; min_lat = 0; max_lat = 4; rand_err = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                ra = $urandom & 32'hFFFF_FFFC;
                if ($urandom_range(0, 5) == 0) ra[1:0] = 2'($urandom_range(1, 3));
                do_cycle(1'b1, ra);
            end else begin
                do_cycle(1'b0, '0);
            end
        end

        // Reset in the middle of random traffic.
        mid_reset();
        run(20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage: owns the program counter, issues in-order word fetches to the instruction memory port and buffers returned instructions for decode in a small FIFO. Sits between the instruction memory interface and decode; decode consumes `{pc, insn, trap}` entries through a valid/ready handshake. Fetch faults travel down the pipe as `TrapInfo`. Redirects from the trap/branch logic flush the stage and restart fetch at a new PC.

## Interface
- `FifoDepth`, default 4, number of decode-buffer entries and the maximum number of in-flight plus buffered fetches; power of two, ≥2.
- `clk` in 1: the single clock.
- `rstN` in 1: reset, asynchronous assert, active-low.
- `memReqValid` out 1: fetch request.
- `memReqAddr` out 32: word-aligned fetch address.
- `memReqReady` in 1: memory accepts the request.
- `memRespValid` in 1: response returned; responses arrive in request order, at least 1 cycle after acceptance.
- `memRespInsn` in 32: instruction word (`insn_t`).
- `memRespError` in 1: access fault for this response.
- `redirectValid` in 1: flush and restart.
- `redirectPc` in 32: new PC.
- `outValid` out 1: decode entry available.
- `outReady` in 1: decode consumes the entry.
- `outPc` out 32: PC of the entry.
- `outInsn` out 32: instruction; 0 when the entry carries a trap.
- `outTrap` out `TrapInfo`: `valid`, `cause`, `value`.

## Operation
- State machine `FetchState`: RUN, HALT. Reset → RUN.
- Registers: `pc` (reset `InitialProgramCounter` = 0x1000), `respPc` (PC of the oldest in-flight fetch, reset 0x1000), `inflight` and `dropCount` (width $clog2(FifoDepth)+1, reset 0), FIFO (reset empty).
- Credit: a request may issue only while `inflight + fifoCount < FifoDepth`.
- `memReqValid` = RUN && `pc[1:0]`==0 && credit && !`redirectValid`; `memReqAddr` = `pc`. On acceptance: `pc += InsnSize` (wraps modulo 2^32), `inflight++`.
- Response while `dropCount`≠0: discarded, `dropCount--`, `inflight--`.
- Response otherwise: push `{respPc, memRespInsn, no trap}`, `respPc += 4`, `inflight--`. If `memRespError`: push `{respPc, 0, trap(cause = instruction access fault (1), value = respPc)}`, set `dropCount = inflight-1` (count before decrement), go HALT.
- Misaligned PC: in RUN with `pc[1:0]`≠0, once `inflight`==0 and the FIFO is not full, push `{pc, 0, trap(cause = instruction address misaligned (0), value = pc)}` and go HALT.
- HALT: no requests; the FIFO keeps draining to decode; only a redirect leaves HALT.
- Redirect (any state): FIFO cleared, `pc = respPc = redirectPc`, `dropCount = inflight` (the net count after this cycle's events), state → RUN. A response or a pop in the same cycle is overridden: the response counts as dropped and the pop is discarded.
- `outValid` = FIFO not empty; outputs show the FIFO head.

## Timing
- A request is accepted in cycle N → its response arrives in cycle ≥N+1 → it is pushed in that cycle → `outValid` is asserted from the next edge. Minimum fetch-to-decode latency: 2 cycles after acceptance.
- The FIFO sustains 1 push and 1 pop per cycle, including when full. Credit makes overflow impossible.
- After a redirect in cycle N, the first request using the new PC can issue in cycle N+1.
- Reset mid-operation: all state returns to its reset values immediately. Responses already in flight at reset are the memory side's responsibility.

## Configuration
- `FETCH_STAGE_PERF_EN`
  - Defined: adds output ports `perfFetchCount` (32 bits, incremented on every non-trap push) and `perfDropCount` (32 bits, incremented on every discarded response and for every entry flushed from the FIFO). Both reset to 0 and wrap.
  - Undefined: the ports and counters do not exist. All other behaviour is identical.

## Structure
- Shared package (`ProcessorTypes`):
  - `FetchState` enum.
  - `FetchEntry` struct {`word_t pc`; `insn_t insn`; `TrapInfo trap`}.
  - Exception-cause constants used by fetch.
- Sub-module `fetch_fifo`: parameterised synchronous FIFO of `FetchEntry` with a clear input, count, full and empty outputs, and the same `clk`/`rstN`.

## Test plan
- Reset, `memReqReady`=1, memory with 1-cycle latency returning `insn = addr` → requests at 0x1000, 0x1004, …; decode receives `{0x1000, 0x1000}` 2 cycles after the first acceptance.
- `outReady`=0 with `FifoDepth`=4 → exactly 4 requests issue, then `memReqValid` stays 0. Raise `outReady` → issue resumes with one request per pop.
- Redirect to 0x2000 with 3 fetches in flight → the 3 late responses are discarded, the FIFO is emptied, and the next request and first decode entry are at 0x2000.
- Redirect to 0x2002 → no request issues; one entry `{0x2002, 0, trap(cause 0, value 0x2002)}`; then HALT. A later redirect to 0x3000 resumes fetch.
- `memRespError` on the 0x1008 response with 2 more fetches in flight → entry with `trap(cause 1, value 0x1008)`; the following 2 responses are dropped; no further requests until a redirect.
- Redirect in the same cycle as `memRespValid` and `outValid`&&`outReady` → the response is dropped, no entry is delivered, and the counters stay consistent, checked with `FETCH_STAGE_PERF_EN` defined.
